// File: rtl/bb_dig_pkg.sv
// bb_dig_pkg: shared types and constants for the binary-to-BCD converter
// and its optional 7-segment decoder (BB_DIG_SEG7_EN).
package bb_dig_pkg;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [6:0] seg_t;        // {g,f,e,d,c,b,a}, active high

  // Converted result: tens digit is a single bit since the input tops out at 15
  typedef struct packed {
    logic       tens;
    bcd_digit_t units;
  } bcd_res_t;

  localparam bcd_digit_t BCD_TEN   = 4'd10;
  localparam seg_t       SEG_BLANK = 7'b0000000;
  localparam seg_t       SEG_ONE   = 7'b0000110;

  localparam seg_t SEG_GLYPH [0:9] = '{
    7'b0111111,  // 0
    7'b0000110,  // 1
    7'b1011011,  // 2
    7'b1001111,  // 3
    7'b1100110,  // 4
    7'b1101101,  // 5
    7'b1111101,  // 6
    7'b0000111,  // 7
    7'b1111111,  // 8
    7'b1101111   // 9
  };

endpackage

// File: rtl/bb_dig_seg7.sv
// bb_dig_seg7: combinational BCD digit to 7-segment decoder with blanking.
// Codes above 9 cannot come out of the converter; they decode to blank.
module bb_dig_seg7
  import bb_dig_pkg::*;
(
  input  bcd_digit_t digit,
  input  logic       blank,
  output seg_t       seg
);

  // Glyph lookup, forced blank on request or out-of-range digit
  always_comb begin
    seg = SEG_BLANK;
    if (!blank && (digit <= 4'd9))
      seg = SEG_GLYPH[digit];
  end

endmodule

// File: rtl/bb_dig.sv
// bb_dig: registered 4-bit binary to 2-digit BCD converter, 1-cycle latency.
// Outputs load only on in_valid edges and hold otherwise; out_valid is a
// one-cycle strobe per accepted input.
// Optional: define BB_DIG_SEG7_EN to add registered 7-segment outputs
// seg_tens / seg_units (tens digit leading-zero suppressed).
module bb_dig
  import bb_dig_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       A3,
  input  logic       A2,
  input  logic       A1,
  input  logic       A0,
  output logic       out_valid,
  output logic       B4,
  output logic       B3,
  output logic       B2,
  output logic       B1,
  output logic       B0
`ifdef BB_DIG_SEG7_EN
  ,
  output logic [6:0] seg_tens,
  output logic [6:0] seg_units
`endif
);

  logic [3:0] a;
  bcd_res_t   nxt;
  bcd_res_t   res;

  assign a = {A3, A2, A1, A0};

  // Compare/subtract conversion; result only reaches the register when
  // in_valid is high, so X on A while idle never lands in state
  always_comb begin
    nxt       = '0;
    nxt.tens  = (a >= BCD_TEN);
    nxt.units = nxt.tens ? (a - BCD_TEN) : a;
  end

  // Result register with load enable, valid strobe follows in_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid)
        res <= nxt;
    end
  end

  assign B4 = res.tens;
  assign {B3, B2, B1, B0} = res.units;

`ifdef BB_DIG_SEG7_EN
  seg_t seg_tens_nxt;
  seg_t seg_units_nxt;

  // Tens digit is 0 or 1; blanking on 0 suppresses the leading zero
  bb_dig_seg7 u_seg_tens (
    .digit ({3'b000, nxt.tens}),
    .blank (!nxt.tens),
    .seg   (seg_tens_nxt)
  );

  bb_dig_seg7 u_seg_units (
    .digit (nxt.units),
    .blank (1'b0),
    .seg   (seg_units_nxt)
  );

  // Segment registers load alongside the BCD result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_tens  <= SEG_BLANK;
      seg_units <= SEG_BLANK;
    end else if (in_valid) begin
      seg_tens  <= seg_tens_nxt;
      seg_units <= seg_units_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_bb_dig.sv
// tb_bb_dig: scoreboard bench for bb_dig. Expected BCD values are pushed
// when an input is driven with in_valid=1 and popped one cycle later.
module tb_bb_dig;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic A3, A2, A1, A0;
  logic out_valid;
  logic B4, B3, B2, B1, B0;
`ifdef BB_DIG_SEG7_EN
  logic [6:0] seg_tens, seg_units;
`endif

  bb_dig dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A3        (A3),
    .A2        (A2),
    .A1        (A1),
    .A0        (A0),
    .out_valid (out_valid),
    .B4        (B4),
    .B3        (B3),
    .B2        (B2),
    .B1        (B1),
    .B0        (B0)
`ifdef BB_DIG_SEG7_EN
    ,
    .seg_tens  (seg_tens),
    .seg_units (seg_units)
`endif
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [4:0] exp_q [$];
  logic [4:0] e;
  wire  [4:0] bout = {B4, B3, B2, B1, B0};

  // Reference: decimal tens and units of v
  function automatic logic [4:0] ref_bcd(input int v);
    logic [4:0] r;
    r[4]   = ((v / 10) != 0);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  // Drive one input cycle's worth of stimulus (called at negedge)
  task automatic drive(input logic v, input logic [3:0] val);
    in_valid = v;
    {A3, A2, A1, A0} = val;
    if (v) exp_q.push_back(ref_bcd(int'(val)));
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 1'b1;
    {A3, A2, A1, A0} = 4'b1111;
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if (bout !== 5'b0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold got ov=%b bcd=%b want ov=0 bcd=00000", out_valid, bout);
    end
`ifdef BB_DIG_SEG7_EN
    n_cmp++;
    if (seg_tens !== 7'b0 || seg_units !== 7'b0) begin
      n_err++;
      $display("FAIL reset_seg got %b/%b want blank", seg_tens, seg_units);
    end
`endif
    rst_n = 1'b1;
    drive(1'b1, 4'd5);
    @(posedge clk); @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if (bout !== e || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release got ov=%b bcd=%b want ov=1 bcd=%b", out_valid, bout, e);
    end
    // async assert mid-cycle, checked before the next rising edge
    drive(1'b0, 4'd0);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bout !== 5'b0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async got ov=%b bcd=%b want ov=0 bcd=00000", out_valid, bout);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sweep;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'(i));
      @(posedge clk); @(negedge clk);
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL sweep_queue empty at a=%0d", i);
      end else begin
        e = exp_q.pop_front();
        n_cmp++;
        if (bout !== e || out_valid !== 1'b1) begin
          n_err++;
          $display("FAIL sweep a=%0d got ov=%b bcd=%b want ov=1 bcd=%b", i, out_valid, bout, e);
        end
      end
      if (i == 9 || i == 10 || i == 15) begin
        n_cmp++;
        if ((i == 9  && bout !== 5'b0_1001) ||
            (i == 10 && bout !== 5'b1_0000) ||
            (i == 15 && bout !== 5'b1_0101)) begin
          n_err++;
          $display("FAIL sweep_edge a=%0d got bcd=%b", i, bout);
        end
      end
    end
  endtask

  task automatic test_hold;
    drive(1'b1, 4'd13);
    @(posedge clk); @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if (bout !== e || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL hold_load got ov=%b bcd=%b want ov=1 bcd=%b", out_valid, bout, e);
    end
    for (int k = 0; k < 8; k++) begin
      if (k < 2) begin
        in_valid = 1'b0;
        {A3, A2, A1, A0} = 4'bxxxx;
      end else begin
        drive(1'b0, 4'($urandom_range(15)));
      end
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (bout !== 5'b1_0011 || out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL hold k=%0d got ov=%b bcd=%b want ov=0 bcd=10011", k, out_valid, bout);
      end
    end
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 4'd9);
    @(posedge clk); @(negedge clk);
    drive(1'b1, 4'd10);
    e = exp_q.pop_front();
    n_cmp++;
    if (bout !== e || bout !== 5'b0_1001 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_9 got ov=%b bcd=%b want ov=1 bcd=%b", out_valid, bout, e);
    end
    @(posedge clk); @(negedge clk);
    drive(1'b0, 4'd3);
    e = exp_q.pop_front();
    n_cmp++;
    if (bout !== e || bout !== 5'b1_0000 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_10 got ov=%b bcd=%b want ov=1 bcd=%b", out_valid, bout, e);
    end
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || bout !== 5'b1_0000) begin
      n_err++;
      $display("FAIL b2b_idle got ov=%b bcd=%b want ov=0 bcd=10000", out_valid, bout);
    end
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 4'd12);
    @(posedge clk); @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if (bout !== e || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL mid_load got ov=%b bcd=%b want ov=1 bcd=%b", out_valid, bout, e);
    end
    // pending input 3 must be discarded by the reset
    in_valid = 1'b1;
    {A3, A2, A1, A0} = 4'd3;
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bout !== 5'b0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_async got ov=%b bcd=%b want ov=0 bcd=00000", out_valid, bout);
    end
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if (bout !== 5'b0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_discard got ov=%b bcd=%b want ov=0 bcd=00000", out_valid, bout);
    end
    rst_n = 1'b1;
    drive(1'b1, 4'd7);
    @(posedge clk); @(negedge clk);
    drive(1'b0, 4'd0);
    e = exp_q.pop_front();
    n_cmp++;
    if (bout !== e || bout !== 5'b0_0111 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL mid_after got ov=%b bcd=%b want ov=1 bcd=%b", out_valid, bout, e);
    end
  endtask

`ifdef BB_DIG_SEG7_EN
  task automatic test_seg7;
    drive(1'b1, 4'd15);
    @(posedge clk); @(negedge clk);
    drive(1'b1, 4'd8);
    e = exp_q.pop_front();
    n_cmp++;
    if (bout !== e || seg_tens !== 7'b0000110 || seg_units !== 7'b1101101) begin
      n_err++;
      $display("FAIL seg_15 got bcd=%b seg=%b/%b want bcd=%b seg=0000110/1101101", bout, seg_tens, seg_units, e);
    end
    @(posedge clk); @(negedge clk);
    drive(1'b0, 4'd0);
    e = exp_q.pop_front();
    n_cmp++;
    if (bout !== e || seg_tens !== 7'b0000000 || seg_units !== 7'b1111111) begin
      n_err++;
      $display("FAIL seg_8 got bcd=%b seg=%b/%b want bcd=%b seg=0000000/1111111", bout, seg_tens, seg_units, e);
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    {A3, A2, A1, A0} = 4'd0;
    @(negedge clk);
    test_reset();
    test_sweep();
    test_hold();
    test_back_to_back();
    test_reset_mid();
`ifdef BB_DIG_SEG7_EN
    test_seg7();
`endif
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain got %0d left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bb_dig.md
Name: bb_dig

Overview:
- Registered 4-bit binary to 2-digit BCD converter.
- Input A3..A0 is an unsigned value 0..15.
- Output is a 1-bit tens digit (B4) plus a 4-bit units digit (B3..B0).
- Sits as a leaf datapath block feeding display or decimal-formatting logic; one clock domain.

Parameters:
- none (widths fixed by the bit-level port list)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous assert, active-low
- in_valid  input  1  qualifies A3..A0 for capture this cycle
- A3  input  1  binary input MSB (weight 8)
- A2  input  1  binary input bit (weight 4)
- A1  input  1  binary input bit (weight 2)
- A0  input  1  binary input LSB (weight 1)
- out_valid  output  1  B4..B0 hold a result converted from a captured input
- B4  output  1  BCD tens digit (0 or 1)
- B3  output  1  BCD units digit bit 3 (weight 8)
- B2  output  1  BCD units digit bit 2
- B1  output  1  BCD units digit bit 1
- B0  output  1  BCD units digit bit 0

Behaviour:
- Reset values: B4..B0 = 0, out_valid = 0 while rst_n = 0.
  - Assertion of rst_n = 0 takes effect immediately, independent of clk.
  - Release of rst_n is sampled on a rising edge.
- Arithmetic: A = {A3,A2,A1,A0}.
  - Tens: B4 = 1 if A >= 10, else 0.
  - Units: {B3,B2,B1,B0} = A - 10*B4, always in range 0..9.
- Full mapping:
  - 0..9 -> B4=0, units=A.
  - 10 -> 1_0000, 11 -> 1_0001, 12 -> 1_0010, 13 -> 1_0011, 14 -> 1_0100, 15 -> 1_0101.
- Latency: 1 cycle.
  - On a rising edge with in_valid = 1, outputs load the conversion of the A sampled at that edge.
  - out_valid goes to 1 on the same edge.
- Edge with in_valid = 0: B4..B0 hold the last result. out_valid = 0 for that cycle.
  - out_valid is a one-cycle strobe per accepted input.
- Back-to-back: in_valid high on consecutive edges gives one result per cycle, no stall and no backpressure.
- Reset mid-stream: pending input is discarded, outputs return to 0, out_valid = 0.
  - The first valid input after reset release is converted normally.
- No illegal input exists: all 16 codes are defined. Outputs never show units > 9.
- Combinational core has no X-propagation dependence: X on A when in_valid = 0 must not disturb the outputs.

Optional Feature:
- Macro: BB_DIG_SEG7_EN.
- Defined:
  - Adds outputs seg_tens[6:0] and seg_units[6:0], active-high segments ordered {g,f,e,d,c,b,a}.
  - Registered on the same edge as B4..B0, so same 1-cycle latency and same hold behaviour.
  - Reset value is blank (7'b0000000).
  - seg_tens shows blank when B4 = 0 (leading-zero suppression) and "1" (7'b0000110) when B4 = 1.
  - seg_units uses the standard 0-9 glyphs: 0 = 7'b0111111, 5 = 7'b1101101, 8 = 7'b1111111.
- Undefined: those ports and that logic are absent. Core behaviour is unchanged.

Decomposition:
- Package bb_dig_pkg:
  - typedef bcd_digit_t (4-bit)
  - constant BCD_TEN = 10
  - constant 7-segment glyph table SEG_GLYPH[0:9]
  - constants SEG_BLANK and SEG_ONE
- Sub-module bb_dig_seg7: pure combinational BCD digit -> 7-segment decoder with blank input.
  - Instantiated twice only under BB_DIG_SEG7_EN.
- Conversion compare/subtract stays inline in bb_dig.

Test Plan:
- Reset: hold rst_n = 0, drive A = 4'b1111, in_valid = 1 -> B4..B0 = 0 and out_valid = 0. Assert rst_n asynchronously mid-cycle -> outputs clear before the next edge.
- Exhaustive sweep: A = 0..15, one per cycle, with in_valid = 1 -> each result 1 cycle later with out_valid = 1. Check 9 -> 0_1001, 10 -> 1_0000, 15 -> 1_0101.
- Hold: convert A = 13 (-> 1_0011), then in_valid = 0 while A toggles randomly -> outputs stay 1_0011 and out_valid = 0.
- Boundary: A = 9 then A = 10 back-to-back -> 0_1001 then 1_0000 on consecutive cycles, out_valid high both cycles.
- Reset mid-stream: A = 12 accepted, rst_n pulsed low before the next edge -> outputs 0. After release, A = 7 -> 0_0111.
- With BB_DIG_SEG7_EN: A = 15 -> seg_tens = 7'b0000110, seg_units = 7'b1101101. A = 8 -> seg_tens = 7'b0000000, seg_units = 7'b1111111.
